// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg: shared dbus request/response types and arbiter state encoding
package common;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

package pipes;
    typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/dbus_arbiter_picker.sv
// arb_picker: picks the first valid requester at or after base (wrapping), one-hot and encoded
module arb_picker #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] base,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    int best;
    always_comb begin
        idx = '0;
        best = N;
        for (int j = 0; j < N; j++)
            if (valid[j] && ((j + N - int'(base)) % N) < best) begin
                best = (j + N - int'(base)) % N;
                idx = W'(j);
            end
        any = |valid;
        grant = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: locks the shared dbus to one master until data_ok; DBUS_ARB_RR_EN selects round-robin over fixed priority
module dbus_arbiter
    import common::*;
    import pipes::*;
#(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  dbus_req_t               ireq [NREQ],
    output dbus_resp_t              iresp [NREQ],
    output dbus_req_t               dreq,
    input  dbus_resp_t              dresp,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);
    localparam int W = $clog2(NREQ);
    arb_state_t state_q, state_d;
    logic [W-1:0] lock_q, lock_d, base, win;
    logic [NREQ-1:0] valid, grant;
    logic any;
    dbus_req_t idle_req;

`ifdef DBUS_ARB_RR_EN
    logic [W-1:0] last_q, last_d;
    logic done;
    assign base = (last_q == W'(NREQ - 1)) ? '0 : last_q + 1'b1;
    assign done = dresp.data_ok && dreq.valid;
    assign last_d = done ? owner : last_q;
    always_ff @(posedge clk) last_q <= reset ? W'(NREQ - 1) : last_d;
`else
    assign base = '0;
`endif

    arb_picker #(.N(NREQ), .W(W)) u_picker (
        .valid(valid),
        .base (base),
        .grant(grant),
        .idx  (win),
        .any  (any)
    );

    always_comb begin
        idle_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            valid[i] = ireq[i].valid;
            idle_req = idle_req | (grant[i] ? ireq[i] : '0);
        end
    end

    // Payload is never latched: in BUSY the owner's live request is passed through verbatim.
    always_comb begin
        busy = state_q == BUSY;
        dreq = busy ? ireq[lock_q] : idle_req;
        owner = busy ? lock_q : win;
        state_d = busy ? ((dresp.data_ok || !ireq[lock_q].valid) ? IDLE : BUSY)
                       : ((any && !dresp.data_ok) ? BUSY : IDLE);
        lock_d = busy ? lock_q : win;
        for (int i = 0; i < NREQ; i++) begin
            iresp[i].data = dresp.data;
            iresp[i].data_ok = dresp.data_ok && dreq.valid && owner == W'(i);
            iresp[i].addr_ok = dresp.addr_ok && dreq.valid && owner == W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q <= lock_d;
        end
    end
endmodule
